// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard-driven PC/IF/ID/ID/EX control,
// data-cache miss freeze with refill handshake and timeout guard, and a saturating stall counter.
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             miss_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             MemStall_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic             mem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             mem_req_q, mem_req_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_write, mem_stall, ifid_write, ifid_flush, idex_flush;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        pc_write   = 1'b0;
        mem_stall  = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        case (state_q)
            S_BOOT: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                // Miss outranks load-use, which outranks a taken branch.
                if (miss_i) begin
                    mem_stall = 1'b1;
                    state_d   = S_MISS;
                    tmo_d     = '0;
                end else if (load_use_i) begin
                    idex_flush = 1'b1;
                end else if (branch_taken_i) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            S_MISS: begin
                mem_stall = 1'b1;
                tmo_d     = tmo_q + TW'(1);
                // An ack on the final timeout cycle still counts as a successful refill.
                if (mem_ack_i)               state_d = S_REFILL;
                else if (tmo_q == TMO_LAST)  state_d = S_HALT;
            end
            S_REFILL: begin
                mem_stall = 1'b1;
                state_d   = S_RUN;
            end
            S_HALT: begin
                mem_stall = 1'b1;
            end
            default: state_d = S_BOOT;
        endcase

        mem_req_d   = (state_d == S_MISS);
        err_d       = err_q | (state_d == S_HALT);
        stall_cnt_d = stall_cnt_q;
        if ((mem_stall || idex_flush) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_BOOT;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PCWrite_o    = pc_write;
    assign MemStall_o   = mem_stall;
    assign IFID_write_o = ifid_write;
    assign IFID_flush_o = ifid_flush;
    assign IDEX_flush_o = idex_flush;
    assign mem_req_o    = mem_req_q;
    assign err_o        = err_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: each directed cycle pushes its hand-computed
// output snapshot; a negedge monitor pops and compares against the DUT.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    // {PCWrite, MemStall, IFID_write, IFID_flush, IDEX_flush, mem_req, err}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_RUN   = 7'b1010000;
    localparam logic [6:0] O_LU    = 7'b0000100;
    localparam logic [6:0] O_BR    = 7'b1011000;
    localparam logic [6:0] O_RMISS = 7'b0100000;
    localparam logic [6:0] O_MISS  = 7'b0100010;
    localparam logic [6:0] O_REF   = 7'b0100000;
    localparam logic [6:0] O_HALT  = 7'b0100001;

    logic clk_i = 1'b0;
    logic rst_i, start_i, load_use_i, branch_taken_i, miss_i, mem_ack_i;
    logic PCWrite_o, MemStall_o, IFID_write_o, IFID_flush_o, IDEX_flush_o, mem_req_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    typedef struct {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] cnt;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [6:0] act_ctl;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .load_use_i     (load_use_i),
        .branch_taken_i (branch_taken_i),
        .miss_i         (miss_i),
        .mem_ack_i      (mem_ack_i),
        .PCWrite_o      (PCWrite_o),
        .MemStall_o     (MemStall_o),
        .IFID_write_o   (IFID_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_flush_o   (IDEX_flush_o),
        .mem_req_o      (mem_req_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: one snapshot per cycle, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            act_ctl = {PCWrite_o, MemStall_o, IFID_write_o, IFID_flush_o,
                       IDEX_flush_o, mem_req_o, err_o};
            checks++;
            if (act_ctl !== mon_e.ctl) begin
                errors++;
                $display("FAIL ctl step %0d: got %b expected %b", mon_e.id, act_ctl, mon_e.ctl);
            end
            checks++;
            if (stall_cnt_o !== mon_e.cnt) begin
                errors++;
                $display("FAIL stall_cnt step %0d: got %0d expected %0d", mon_e.id, stall_cnt_o, mon_e.cnt);
            end
            $display("step %0d: ctl=%b cnt=%0d", mon_e.id, act_ctl, stall_cnt_o);
        end
    end

    task automatic step(input logic r, input logic s, input logic l, input logic b,
                        input logic m, input logic a,
                        input logic [6:0] c, input logic [CNT_W-1:0] n);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i = r; start_i = s; load_use_i = l; branch_taken_i = b; miss_i = m; mem_ack_i = a;
        e.ctl = c; e.cnt = n; e.id = step_id;
        exp_q.push_back(e);
        step_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; load_use_i = 1'b0;
        branch_taken_i = 1'b0; miss_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Boot, hazards, miss with ack after 5 MISS cycles, back-to-back miss.
        step(1,0,0,0,0,0, O_IDLE, 0);
        step(1,1,0,0,1,0, O_IDLE, 0);
        step(1,0,0,0,0,0, O_RUN, 0);
        step(1,1,0,0,0,0, O_RUN, 0);
        step(1,0,1,1,0,0, O_LU, 0);
        step(1,0,0,1,0,0, O_BR, 1);
        step(1,0,0,0,0,0, O_RUN, 1);
        step(1,0,0,0,1,0, O_RMISS, 1);
        step(1,0,0,0,1,0, O_MISS, 2);
        step(1,0,1,1,1,0, O_MISS, 3);
        step(1,0,0,0,1,0, O_MISS, 4);
        step(1,0,0,0,1,0, O_MISS, 5);
        step(1,0,0,0,1,1, O_MISS, 6);
        step(1,0,0,0,1,0, O_REF, 7);
        step(1,0,0,0,1,0, O_RMISS, 8);
        step(1,0,0,0,1,1, O_MISS, 9);
        step(1,0,0,0,0,0, O_REF, 10);
        step(1,0,0,0,0,0, O_RUN, 11);

        // Reset, then timeout into HALT and counter saturation.
        step(0,0,0,0,0,0, O_RUN, 11);
        step(1,1,0,0,0,0, O_IDLE, 0);
        step(1,0,0,0,1,0, O_RMISS, 0);
        for (int i = 0; i < 8; i++) step(1,1,0,0,1,0, O_MISS, 4'(i + 1));
        for (int i = 0; i < 11; i++) step(1,1,1,1,0,0, O_HALT, (9 + i > 15) ? 4'd15 : 4'(9 + i));
        step(0,0,0,0,0,0, O_HALT, 15);
        step(1,0,0,0,0,0, O_IDLE, 0);

        // Ack on the final timeout cycle; miss outranks load-use and branch.
        step(1,1,0,0,0,0, O_IDLE, 0);
        step(1,0,1,1,1,0, O_RMISS, 0);
        for (int i = 0; i < 7; i++) step(1,0,0,0,1,0, O_MISS, 4'(i + 1));
        step(1,0,0,0,1,1, O_MISS, 8);
        step(1,0,0,0,0,0, O_REF, 9);
        step(1,0,0,0,0,0, O_RUN, 10);

        // Reset mid-miss, then a late ack.
        step(1,0,0,0,1,0, O_RMISS, 10);
        step(1,0,0,0,1,0, O_MISS, 11);
        step(0,0,0,0,1,0, O_MISS, 12);
        step(1,0,0,0,1,1, O_IDLE, 0);
        step(1,0,0,0,0,0, O_IDLE, 0);

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It derives the PC write enable, IF/ID write/flush and ID/EX bubble from load-use and branch events. It freezes the whole pipeline on a data-cache miss and runs the refill request/acknowledge handshake with off-chip memory, including a timeout guard. It also keeps a saturating stall-cycle counter for performance measurement. It sits beside the hazard detection logic and drives the PC register and the pipeline-register enables.

## Interface
- TIMEOUT, default 64: maximum cycles to wait for mem_ack_i before declaring a fault; legal range is 2..1023.
- CNT_W, default 32: width of the stall counter.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-low; 0 on a rising edge resets the block.
- start_i  in  1  CPU run enable; sampled only in BOOT.
- load_use_i  in  1  ID-stage load-use hazard detected.
- branch_taken_i  in  1  ID-stage branch resolved taken.
- miss_i  in  1  data cache miss for the current MEM-stage access; held high until the refill completes.
- mem_ack_i  in  1  off-chip memory refill data valid; one-cycle pulse.
- PCWrite_o  out  1  PC register write enable.
- MemStall_o  out  1  global memory stall to the PC and all pipeline registers.
- IFID_write_o  out  1  IF/ID register write enable.
- IFID_flush_o  out  1  IF/ID flush (inject NOP).
- IDEX_flush_o  out  1  ID/EX flush (bubble).
- mem_req_o  out  1  refill request to off-chip memory.
- err_o  out  1  sticky memory-timeout fault.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

## Operation
- States: BOOT, RUN, MISS, REFILL, HALT. The reset state is BOOT.
- BOOT:
  - All enables and flushes are 0. MemStall_o=0, mem_req_o=0.
  - start_i=1 moves to RUN on the next edge.
- RUN: outputs are a function of the inputs (Mealy). Priority is miss_i > load_use_i > branch_taken_i.
  - miss_i=1:
    - MemStall_o=1; PCWrite_o=0; IFID_write_o=0; all flushes 0.
    - Next state is MISS; the timeout counter loads 0.
  - Otherwise, load_use_i=1:
    - PCWrite_o=0, IFID_write_o=0, IDEX_flush_o=1, IFID_flush_o=0.
    - branch_taken_i is ignored this cycle; it re-presents after the bubble.
  - Otherwise, branch_taken_i=1: PCWrite_o=1, IFID_write_o=1, IFID_flush_o=1, IDEX_flush_o=0.
  - Otherwise: PCWrite_o=1, IFID_write_o=1, flushes 0, MemStall_o=0.
- MISS:
  - mem_req_o=1 and MemStall_o=1; enables and flushes are 0.
  - The timeout counter increments each cycle.
  - mem_ack_i=1 moves to REFILL. mem_ack_i and timeout expiring in the same cycle: ack wins.
  - Counter reaching TIMEOUT-1 without ack moves to HALT and sets err_o.
- REFILL:
  - One cycle; MemStall_o=1 so the cache writes the line; mem_req_o=0.
  - Unconditionally returns to RUN. miss_i is re-evaluated there, so a second miss starts a new MISS.
- HALT:
  - MemStall_o=1; all enables and flushes 0; mem_req_o=0.
  - Exits only via reset.
- start_i is ignored outside BOOT.
- load_use_i and branch_taken_i are ignored in MISS, REFILL and HALT. The frozen pipeline holds them for re-evaluation in RUN.
- stall_cnt_o increments by 1 on each edge where MemStall_o=1 or IDEX_flush_o=1.
  - It saturates at 2^CNT_W-1 with no wrap.
  - It is cleared only by reset.

## Timing
- Reset values:
  - state=BOOT, stall_cnt_o=0, err_o=0, mem_req_o=0.
  - PCWrite_o=0, IFID_write_o=0, flushes 0, MemStall_o=0.
- In RUN, miss_i, load_use_i and branch_taken_i reach outputs combinationally in the same cycle.
- mem_req_o, err_o and stall_cnt_o are registered and change only at clock edges.
- Miss penalty with ack arriving k cycles after MISS entry (k>=1) is 1 (RUN detect) + k + 1 (REFILL) stall cycles.
- mem_req_o rises on the edge entering MISS. It falls on the edge after mem_ack_i is sampled high. It is never asserted for two separate misses without an intervening low cycle.
- Reset asserted mid-miss: the next edge enters BOOT with mem_req_o=0. A late mem_ack_i is ignored.
- err_o rises on the edge entering HALT and stays high until reset.

## Test plan
- Reset, then start_i=1 for 1 cycle with no hazards:
  - BOOT for 1 cycle, then PCWrite_o=1 and IFID_write_o=1 every cycle.
  - stall_cnt_o stays 0 and err_o=0.
- In RUN, pulse load_use_i and branch_taken_i together for 1 cycle:
  - PCWrite_o=0, IFID_write_o=0, IDEX_flush_o=1, IFID_flush_o=0.
  - stall_cnt_o becomes 1.
  - Then branch_taken_i alone gives IFID_flush_o=1 with PCWrite_o=1.
- miss_i=1, mem_ack_i pulsed 5 cycles after mem_req_o rises:
  - MemStall_o=1 for exactly 7 cycles; mem_req_o high for 5 cycles.
  - stall_cnt_o advances by 7; then back-to-back miss_i starts a fresh request.
- TIMEOUT=8, miss_i=1, no ack:
  - mem_req_o high for 8 cycles, then err_o=1 and state HALT.
  - MemStall_o stays 1 until rst_i=0.
- mem_ack_i on the last timeout cycle: enters REFILL, err_o stays 0.
- rst_i=0 during MISS followed by a late mem_ack_i:
  - Outputs take reset values on that edge; mem_req_o=0.
  - The late ack causes no state change.
  - CNT_W=4 forced through 20 stall cycles holds stall_cnt_o at 15.
